nerve_systolic_array: RTL and testbench
=======================================

// Module: nerve_systolic_array
// PURPOSE
// - Weight-stationary systolic MAC array for the fully-connected ("nerve") layers of the CNN.
// - NumOfInputs rows x NumOfNerves columns of PEs; PE(r,c) holds weight W[r][c].
// - Computes out[c] = psum_in[c] + sum_r x[r]*W[r][c] per input vector.
// - Outputs arrive deskewed: one vector result per cycle.
// PARAMETERS
// - BitSize        8  width of activations, partial sums and outputs
// - Weight_BitSize 2  active weight precision; low bits of each weight slot, signed two's complement
// - M_W_BitSize    8  storage width of one weight slot on in_weights
// - NumOfInputs    2  array rows = input vector length
// - NumOfNerves    3  array columns = neurons
// PORTS
// - clk            in   1                        single clock, rising edge
// - res_n          in   1                        reset, asynchronous, active-low
// - in_valid       in   1                        lane-0 element of a vector is present this cycle
// - in_start       in   1                        tags the vector as first of a group
// - in_data        in   NumOfInputs*BitSize      lane r = x[r], signed; caller skews lane r by r cycles
// - in_weights     in   NumOfNerves*M_W_BitSize  one weight row, slot c = W[.][c]
// - in_partial_sum in   NumOfNerves*BitSize      top-of-column seed, signed; caller skews lane c by c cycles
// - en_l_b         in   1                        load enable for weight rows
// - out_valid      out  1                        out_data holds one vector result
// - out_done       out  1                        this result is the last of its group
// - out_data       out  [NumOfNerves][BitSize]   signed column results
// BEHAVIOUR
// - Reset (async, res_n=0): all weights, data/psum pipes, tags and outputs clear to 0.
// - Weight load:
//   - Each rising edge with en_l_b=1 shifts rows up: W[r] <= W[r+1], W[N-1] <= in_weights.
//   - After NumOfInputs loads, row 0 holds the first word loaded.
//   - Loading may overlap compute; PEs use the new weights from the next edge.
//   - In-flight results during a load are don't-care.
// - Compute pipes run free; there is no stall.
//   - Data pipe: d(r,c) <= d(r,c-1); d(r,-1) = in_data lane r.
//   - Psum pipe: p(r,c) <= p(r-1,c) + d_in(r,c)*sext(W[r][c][Weight_BitSize-1:0]).
//   - p(-1,c) = in_partial_sum lane c.
// - Arithmetic:
//   - Signed product, full width internally.
//   - Each PE's sum is truncated (wraps) to BitSize.
// - Column c result is ready after edge t+NumOfInputs-1+c, where t is the lane-0 sample edge.
//   - Deskew column c by NumOfNerves-1-c registers.
//   - Add one output register stage for out_done lookahead.
// - Latency: lane-0 sample edge -> out_valid high = NumOfInputs+NumOfNerves-1 cycles (4 at defaults).
// - Tags in_valid/in_start enter with lane 0 and travel through a matching delay line.
//   - out_valid = delayed in_valid; out_data is held at 0 when out_valid=0.
// - out_done=1 on a valid beat when the following tag slot is invalid or start-tagged.
//   - in_start=1 with in_valid=0 is ignored.
// - Vectors may be back-to-back every cycle.
// STRUCTURE
// - Shared package nerve_pkg: BitSize/M_W_BitSize defaults, data_t, weight_t, and the sext helper.
// - One sub-module, systolic_pe: weight register, data-forward register, psum MAC register.
// - Top level: PE generate grid, weight shift chain, deskew registers, tag delay line.
// TESTING
// - Weight load: rows (1,1,1) then (1,0,1), x=(7,6) skewed, psum 0 -> out_data=(13,7,13) 4 cycles after lane 0.
// - Signed weights: row0=(2'b11,1,0), row1=0, x=(5,0) -> out=(8'hFB,5,0).
// - Partial sum: same weights as the load test, psum=(1,2,3) skewed, x=(7,6) -> (14,9,16).
// - Streaming: alternate x=(7,0),(0,6) every cycle with in_start on vector 0 -> back-to-back outputs.
//   - Expected results (7,7,7),(6,0,6), ...; out_done on each beat preceding a start or an invalid slot.
// - Wrap: row0=(1,..), x=(127,127) with both row weights 1 -> column wraps to 8'hFE.
// - Reset mid-stream: res_n low for one cycle -> out_valid/out_done/out_data=0 immediately.
//   - Weights must be reloaded afterwards.

Source files
------------

// File: rtl/nerve_pkg.sv
// Shared types and helpers for the nerve-layer systolic MAC array.
// Widths here are the storage defaults used by every PE.
package nerve_pkg;

  localparam int DefBitSize    = 8;
  localparam int DefWeightBits = 2;
  localparam int DefMWBits     = 8;

  typedef logic signed [DefBitSize-1:0]    data_t;
  typedef logic signed [DefWeightBits-1:0] weight_t;

  function automatic data_t sext(input weight_t w);
    return {{(DefBitSize-DefWeightBits){w[DefWeightBits-1]}}, w};
  endfunction

endpackage

// File: rtl/nerve_systolic_array_pe.sv
// One weight-stationary PE: weight register, data forward register
// and a wrapping multiply-accumulate partial-sum register.
module systolic_pe
  import nerve_pkg::*;
(
  input  logic    clk,
  input  logic    res_n,
  input  logic    en_l_b,
  input  weight_t w_i,
  input  data_t   d_i,
  input  data_t   p_i,
  output weight_t w_o,
  output data_t   d_o,
  output data_t   p_o
);

  weight_t w_q;
  data_t   d_q;
  data_t   p_q;
  data_t   p_d;

  logic signed [2*DefBitSize-1:0] prod;

  assign prod = d_i * sext(w_q);
  assign p_d  = data_t'(p_i + prod);

  always_ff @(posedge clk or negedge res_n) begin
    if (!res_n) begin
      w_q <= '0;
      d_q <= '0;
      p_q <= '0;
    end else begin
      if (en_l_b) begin
        w_q <= w_i;
      end
      d_q <= d_i;
      p_q <= p_d;
    end
  end

  assign w_o = w_q;
  assign d_o = d_q;
  assign p_o = p_q;

endmodule

// File: rtl/nerve_systolic_array.sv
// Weight-stationary systolic array for fully-connected layers with
// deskewed column outputs and a valid/start tag line for group ends.
module nerve_systolic_array
  import nerve_pkg::*;
#(
  parameter int BitSize        = DefBitSize,
  parameter int Weight_BitSize = DefWeightBits,
  parameter int M_W_BitSize    = DefMWBits,
  parameter int NumOfInputs    = 2,
  parameter int NumOfNerves    = 3
) (
  input  logic                                clk,
  input  logic                                res_n,
  input  logic                                in_valid,
  input  logic                                in_start,
  input  logic [NumOfInputs*BitSize-1:0]      in_data,
  input  logic [NumOfNerves*M_W_BitSize-1:0]  in_weights,
  input  logic [NumOfNerves*BitSize-1:0]      in_partial_sum,
  input  logic                                en_l_b,
  output logic                                out_valid,
  output logic                                out_done,
  output logic [NumOfNerves-1:0][BitSize-1:0] out_data
);

  localparam int R = NumOfInputs;
  localparam int C = NumOfNerves;
  localparam int D = R + C - 1;

  data_t   dch [R][C+1];
  data_t   pch [R+1][C];
  weight_t wch [R+1][C];

  logic [C-1:0][BitSize-1:0] aligned;

  for (genvar r = 0; r < R; r++) begin : g_din
    assign dch[r][0] = in_data[r*BitSize +: BitSize];
  end

  for (genvar c = 0; c < C; c++) begin : g_top
    assign pch[0][c] = in_partial_sum[c*BitSize +: BitSize];
    assign wch[R][c] = in_weights[c*M_W_BitSize +: Weight_BitSize];
  end

  for (genvar r = 0; r < R; r++) begin : g_row
    for (genvar c = 0; c < C; c++) begin : g_col
      systolic_pe u_pe (
        .clk    (clk),
        .res_n  (res_n),
        .en_l_b (en_l_b),
        .w_i    (wch[r+1][c]),
        .d_i    (dch[r][c]),
        .p_i    (pch[r][c]),
        .w_o    (wch[r][c]),
        .d_o    (dch[r][c+1]),
        .p_o    (pch[r+1][c])
      );
    end
  end

  // Column c finishes c cycles after column 0; delay early columns to match.
  for (genvar c = 0; c < C; c++) begin : g_dsk
    localparam int N = C - 1 - c;
    if (N == 0) begin : g_pass
      assign aligned[c] = pch[R][c];
    end else begin : g_reg
      data_t sk_q [N];
      always_ff @(posedge clk or negedge res_n) begin
        if (!res_n) begin
          for (int k = 0; k < N; k++) begin
            sk_q[k] <= '0;
          end
        end else begin
          sk_q[0] <= pch[R][c];
          for (int k = 1; k < N; k++) begin
            sk_q[k] <= sk_q[k-1];
          end
        end
      end
      assign aligned[c] = sk_q[N-1];
    end
  end

  logic [D-1:0] tv_q;
  logic [D-1:0] ts_q;
  logic [D:0]   tv_d;
  logic [D:0]   ts_d;

  assign tv_d = {tv_q, in_valid};
  assign ts_d = {ts_q, in_start & in_valid};

  logic                      out_valid_q;
  logic                      out_done_q;
  logic [C-1:0][BitSize-1:0] out_data_q;
  logic                      out_valid_d;
  logic                      out_done_d;
  logic [C-1:0][BitSize-1:0] out_data_d;

  always_comb begin
    out_valid_d = tv_d[D];
    out_done_d  = tv_d[D] & (~tv_d[D-1] | ts_d[D-1]);
    out_data_d  = '0;
    if (tv_d[D]) begin
      out_data_d = aligned;
    end
  end

  always_ff @(posedge clk or negedge res_n) begin
    if (!res_n) begin
      tv_q        <= '0;
      ts_q        <= '0;
      out_valid_q <= 1'b0;
      out_done_q  <= 1'b0;
      out_data_q  <= '0;
    end else begin
      tv_q        <= tv_d[D-1:0];
      ts_q        <= ts_d[D-1:0];
      out_valid_q <= out_valid_d;
      out_done_q  <= out_done_d;
      out_data_q  <= out_data_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_done  = out_done_q;
  assign out_data  = out_data_q;

  logic [R-1:0] unused_d;
  logic [C-1:0] unused_w;
  logic         unused_s;

  for (genvar r = 0; r < R; r++) begin : g_ud
    assign unused_d[r] = ^dch[r][C];
  end

  for (genvar c = 0; c < C; c++) begin : g_uw
    assign unused_w[c] = ^{wch[0][c],
      in_weights[c*M_W_BitSize+Weight_BitSize +: M_W_BitSize-Weight_BitSize]};
  end

  assign unused_s = ts_d[D];

endmodule

// File: tb/tb_nerve_systolic_array.sv
// Scoreboard bench for nerve_systolic_array: skewed vector driver,
// reference MAC model and deskewed output monitor.
module tb_nerve_systolic_array;

  localparam int R   = 2;
  localparam int C   = 3;
  localparam int B   = 8;
  localparam int MW  = 8;
  localparam int LAT = R + C - 1;
  localparam int HN  = C;

  logic clk = 1'b0;
  logic res_n = 1'b0;
  logic in_valid = 1'b0;
  logic in_start = 1'b0;
  logic en_l_b = 1'b0;
  logic [R*B-1:0]  in_data = '0;
  logic [C*MW-1:0] in_weights = '0;
  logic [C*B-1:0]  in_partial_sum = '0;
  logic out_valid;
  logic out_done;
  logic [C-1:0][B-1:0] out_data;

  always #5 clk = ~clk;

  nerve_systolic_array dut (
    .clk            (clk),
    .res_n          (res_n),
    .in_valid       (in_valid),
    .in_start       (in_start),
    .in_data        (in_data),
    .in_weights     (in_weights),
    .in_partial_sum (in_partial_sum),
    .en_l_b         (en_l_b),
    .out_valid      (out_valid),
    .out_done       (out_done),
    .out_data       (out_data)
  );

  typedef struct packed {
    logic                v;
    logic                s;
    logic [R-1:0][B-1:0] x;
    logic [C-1:0][B-1:0] p;
  } vec_t;

  typedef struct packed {
    logic [C-1:0][B-1:0] d;
    logic                done;
    int                  cyc;
  } exp_t;

  exp_t exp_q[$];
  vec_t stim[$];
  vec_t hist [HN];
  exp_t mon_e;
  logic [R-1:0][C-1:0][1:0] wm = '0;

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic vec_t mk(input logic v, input logic s,
                              input logic [R-1:0][B-1:0] x,
                              input logic [C-1:0][B-1:0] p);
    vec_t t;
    t.v = v;
    t.s = s;
    t.x = x;
    t.p = p;
    return t;
  endfunction

  function automatic logic [C-1:0][B-1:0] model(input vec_t v);
    logic [C-1:0][B-1:0] res;
    for (int c = 0; c < C; c++) begin
      int acc;
      acc = int'($signed(v.p[c]));
      for (int r = 0; r < R; r++) begin
        logic signed [1:0] wv;
        wv = wm[r][c];
        acc += int'($signed(v.x[r])) * int'(wv);
      end
      res[c] = acc[B-1:0];
    end
    return res;
  endfunction

  task automatic step(input vec_t v, input logic en,
                      input logic [C-1:0][1:0] w);
    logic [5:0] junk;
    @(negedge clk);
    for (int k = HN-1; k > 0; k--) hist[k] = hist[k-1];
    hist[0] = v;
    in_valid = v.v;
    in_start = v.s;
    for (int r = 0; r < R; r++) in_data[r*B +: B] = hist[r].x[r];
    for (int c = 0; c < C; c++) in_partial_sum[c*B +: B] = hist[c].p[c];
    en_l_b = en;
    for (int c = 0; c < C; c++) begin
      junk = 6'($urandom);
      in_weights[c*MW +: MW] = {junk, w[c]};
    end
    if (en) begin
      for (int r = 0; r < R-1; r++) wm[r] = wm[r+1];
      wm[R-1] = w;
    end
  endtask

  task automatic load(input logic [C-1:0][1:0] w);
    step(mk(0, 0, '0, '0), 1'b1, w);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(mk(0, 0, '0, '0), 1'b0, '0);
  endtask

  task automatic issue(input int i);
    exp_t e;
    vec_t v;
    v = stim[i];
    e.d = model(v);
    e.done = (i == stim.size()-1) || !stim[i+1].v || stim[i+1].s;
    step(v, 1'b0, '0);
    e.cyc = cyc;
    if (v.v) exp_q.push_back(e);
  endtask

  task automatic wait_drain();
    for (int i = 0; i < 20 && exp_q.size() > 0; i++) @(negedge clk);
    chk("drain", exp_q.size(), 0);
  endtask

  task automatic run_stim();
    for (int i = 0; i < stim.size(); i++) issue(i);
    idle(HN + 1);
    wait_drain();
    stim.delete();
  endtask

  always @(negedge clk) begin
    if (res_n) begin
      if (out_valid) begin
        if (exp_q.size() == 0) begin
          chk("spurious_valid", 1, 0);
        end else begin
          mon_e = exp_q.pop_front();
          chk("data", out_data, mon_e.d);
          chk("done", out_done, mon_e.done);
          chk("latency", cyc - mon_e.cyc, LAT + 1);
        end
      end else begin
        chk("idle", {out_done, out_data}, 0);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL timeout got=%0d exp=0", exp_q.size());
    $fatal(1, "timeout");
  end

  initial begin
    for (int k = 0; k < HN; k++) hist[k] = '0;
    repeat (2) @(negedge clk);
    chk("rst_valid", out_valid, 0);
    chk("rst_done", out_done, 0);
    chk("rst_data", out_data, 0);
    res_n = 1'b1;
    idle(2);

    load({2'd1, 2'd1, 2'd1});
    load({2'd1, 2'd0, 2'd1});
    stim.push_back(mk(1, 1, {8'd6, 8'd7}, '0));
    run_stim();

    stim.push_back(mk(1, 1, {8'd6, 8'd7}, {8'd3, 8'd2, 8'd1}));
    run_stim();

    for (int i = 0; i < 6; i++)
      stim.push_back(mk(1, i == 0 || i == 4,
                        (i % 2) ? {8'd6, 8'd0} : {8'd0, 8'd7}, '0));
    stim.push_back(mk(0, 1, '0, '0));
    stim.push_back(mk(1, 0, {8'd0, 8'd7}, '0));
    run_stim();

    load({2'd0, 2'd1, 2'd3});
    load({2'd0, 2'd0, 2'd0});
    stim.push_back(mk(1, 1, {8'd0, 8'd5}, '0));
    stim.push_back(mk(1, 0, {8'd0, 8'h80}, {8'd1, 8'd2, 8'h7F}));
    run_stim();

    load({2'd1, 2'd1, 2'd1});
    load({2'd1, 2'd1, 2'd1});
    stim.push_back(mk(1, 1, {8'd127, 8'd127}, '0));
    run_stim();

    for (int i = 0; i < 4; i++)
      stim.push_back(mk(1, i == 0, {8'd3, 8'(i + 1)}, '0));
    for (int i = 0; i < 4; i++) issue(i);
    stim.delete();
    idle(2);
    #2 res_n = 1'b0;
    #1;
    chk("mid_rst_valid", out_valid, 0);
    chk("mid_rst_done", out_done, 0);
    chk("mid_rst_data", out_data, 0);
    exp_q.delete();
    wm = '0;
    for (int k = 0; k < HN; k++) hist[k] = '0;
    in_valid = 1'b0;
    in_start = 1'b0;
    in_data = '0;
    in_partial_sum = '0;
    @(posedge clk);
    #2 res_n = 1'b1;

    stim.push_back(mk(1, 1, {8'd6, 8'd7}, '0));
    run_stim();

    load({2'd1, 2'd1, 2'd1});
    load({2'd1, 2'd0, 2'd1});
    stim.push_back(mk(1, 1, {8'd6, 8'd7}, '0));
    stim.push_back(mk(1, 0, {8'hFF, 8'd2}, {8'd5, 8'd0, 8'hFB}));
    run_stim();

    idle(2);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
